// File: rtl/bram_ctrl.sv
// Initiator-side controller for a single-port bram with 1-cycle registered read latency.
// Optional power-up clear sweep of the whole bram is enabled by defining BRAM_CTRL_CLEAR_EN.
module bram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(RSP_DEPTH);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // Handshakes: a command transfers on a rising edge where cmd_valid & cmd_ready,
    // a response transfers where rsp_valid & rsp_ready; neither ready waits on its valid.

    state_t state_q, state_d;

    logic                  read_pending_q, read_pending_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];

    logic [CNT_W:0] in_use;
    logic           credit_ok;
    logic           rd_accept;
    logic           push;
    logic           pop;

`ifdef BRAM_CTRL_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: begin
`ifdef BRAM_CTRL_CLEAR_EN
                state_d = S_CLEAR;
`else
                state_d = S_RUN;
`endif
            end
            S_CLEAR: begin
`ifdef BRAM_CTRL_CLEAR_EN
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = S_RUN;
                end
`else
                state_d = S_RUN;
`endif
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

`ifdef BRAM_CTRL_CLEAR_EN
    // Sweep address restarts at 0 whenever the FSM re-enters S_CLEAR after a reset.
    always_comb begin
        clr_cnt_d = '0;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    // A read holds a credit from acceptance until its data lands in the FIFO.
    always_comb begin
        in_use    = {1'b0, count_q} + {{CNT_W{1'b0}}, read_pending_q};
        credit_ok = (in_use < DEPTH_V);
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_RUN: begin
                cmd_ready = credit_ok;
                mem_wr    = cmd_valid & credit_ok & cmd_wr;
                mem_addr  = cmd_addr;
                mem_wdata = cmd_wdata;
            end
            S_CLEAR: begin
`ifdef BRAM_CTRL_CLEAR_EN
                mem_wr   = 1'b1;
                mem_addr = clr_cnt_q;
`endif
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != S_RUN) | read_pending_q | (|count_q);
        dbg_state = state_q;
    end

    // ---------------- read tracking and response FIFO ----------------
    always_comb begin
        rd_accept      = cmd_valid & cmd_ready & ~cmd_wr;
        read_pending_d = rd_accept;
        push           = read_pending_q;
        pop            = rsp_valid & rsp_ready;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = mem_rdata;
        end
    end

    always_comb begin
        rsp_valid = (count_q != '0);
        rsp_data  = fifo_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_pending_q <= 1'b0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_q         <= '{default: '0};
        end else begin
            read_pending_q <= read_pending_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_q         <= fifo_d;
        end
    end

    // The credit rule must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (push && !pop) |-> (count_q != CNT_W'(RSP_DEPTH)));

    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst)
        (rsp_valid && !rsp_ready) |=> $stable(rsp_data));

endmodule

// File: tb/tb_bram_ctrl.sv
// Self-checking bench for bram_ctrl with a behavioural 1-cycle-latency bram beside it.
module tb_bram_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef BRAM_CTRL_CLEAR_EN
  localparam int CLR_EDGES = 17;
  localparam logic [DW-1:0] T6_EXP = 32'h0;
`else
  localparam int CLR_EDGES = 1;
  localparam logic [DW-1:0] T6_EXP = 32'h0000_DEAD;
`endif

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [1:0]    dbg_state;

  logic [DW-1:0] bram_mem [2**AW];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
    bit            b2b;
  } vec_t;

  vec_t vecs [34];

  bram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bram: read-before-write, registered output, contents survive reset.
  always @(posedge clk) begin
    if (mem_wr) bram_mem[mem_addr] <= mem_wdata;
    mem_rdata <= bram_mem[mem_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed response is matched against the expected queue.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got 0x%0h, expected no response", rsp_data);
      end else begin
        check("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!done) begin
      @(negedge clk);
      done = cmd_ready;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 50) begin
          n_tests++;
          n_fail++;
          $display("FAIL issue_timeout: got no cmd_ready after %0d cycles, expected acceptance", waited);
          done = 1'b1;
        end
      end
    end
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
  endtask

  // Counts rising edges from the current point until cmd_ready is seen high.
  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (cmd_ready) break;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check("drain_q_empty", exp_q.size(), 0);
    check("drain_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w;
    int n;

    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{1'b1, AW'(i), DW'(i * 3), '0, 1'b0};
      vecs[16 + i] = '{1'b0, AW'(i), '0, DW'(i * 3), 1'b1};
    end
    vecs[32] = '{1'b1, AW'(9), 32'hA5A5_A5A5, '0, 1'b0};
    vecs[33] = '{1'b0, AW'(9), '0, 32'hA5A5_A5A5, 1'b1};

    // Reset state, with a write command presented to prove it is blocked.
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = AW'(5);
    cmd_wdata = 32'hFFFF_FFFF;
    rsp_ready = 1'b0;
    #2;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rst       = 1'b1;
    check("rel_cmd_ready", cmd_ready, 0);
    wait_ready(n);
    check("init_ready_edges", n, CLR_EDGES);
    @(posedge clk);
    #1;

    // Test 1: write then read @3, response exactly two cycles after acceptance.
    issue(1'b1, AW'(3), 32'h0000_0005, w);
    issue(1'b0, AW'(3), '0, w);
    @(negedge clk);
    check("t1_valid_cycle1", rsp_valid, 0);
    @(negedge clk);
    check("t1_valid_cycle2", rsp_valid, 1);
    check("t1_data", rsp_data, 32'h5);
    exp_q.push_back(32'h5);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    // Tests 2 and 4: table of writes then back-to-back reads, plus write/read @9.
    for (int i = 0; i < 34; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, w);
      if (!vecs[i].wr) exp_q.push_back(vecs[i].exp);
      if (vecs[i].b2b) check($sformatf("t2_wait_rd%0d", i), w, 0);
    end
    drain();

    // Test 3: backpressure; only RSP_DEPTH reads accepted until responses drain.
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue(1'b0, AW'(i), '0, w);
      exp_q.push_back(DW'(i * 3));
    end
    @(negedge clk);
    check("t3_ready_full", cmd_ready, 0);
    check("t3_valid", rsp_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_data", rsp_data, 32'd3);
      check("t3_hold_ready", cmd_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    for (int i = 5; i <= 6; i++) begin
      issue(1'b0, AW'(i), '0, w);
      exp_q.push_back(DW'(i * 3));
    end
    drain();

    // Test 5: asynchronous reset drops queued responses.
    rsp_ready = 1'b0;
    issue(1'b0, AW'(1), '0, w);
    issue(1'b0, AW'(2), '0, w);
    @(negedge clk);
    @(negedge clk);
    check("t5_valid_before", rsp_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_valid_async", rsp_valid, 0);
    check("t5_ready_async", cmd_ready, 0);
    check("t5_busy_async", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    wait_ready(n);
    check("t5_ready_edges", n, CLR_EDGES);
    check("t5_no_stale", rsp_valid, 0);
    check("t5_busy_idle", busy, 0);
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_still_empty", rsp_valid, 0);
    @(posedge clk);
    #1;

    // Test 6: bram contents across reset (cleared only with the sweep enabled).
    issue(1'b1, AW'(7), 32'h0000_DEAD, w);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_ready(n);
    check("t6_ready_edges", n, CLR_EDGES);
    @(posedge clk);
    #1;
    issue(1'b0, AW'(7), '0, w);
    exp_q.push_back(T6_EXP);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
